rr_arb4x2: RTL and testbench



---
 rtl/rr_arb4x2.sv | 160 ++++++++++++++++
 tb/tb_rr_arb4x2.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb4x2.sv
// rr_arb4x2 -- four-way round-robin arbiter in front of a shared 4-to-2
// encoded resource. It drives a registered one-hot grant and the matching
// y1/y0 index (x1->00 ... x4->11). A hold limit stops one owner from keeping
// the resource indefinitely while other requesters wait.
module rr_arb4x2 #(
    parameter int MAX_HOLD = 8,   // max consecutive contended grant cycles, 0 = no limit
    parameter int CW       = 4    // hold counter width, 2^CW > MAX_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] y,
    output logic       valid,
    output logic       expire
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam bit            HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

    logic [0:0]    state_reg,  state_next;
    logic [1:0]    ptr_reg,    ptr_next;
    logic [1:0]    owner_reg,  owner_next;
    logic [CW-1:0] cnt_reg,    cnt_next;
    logic [3:0]    gnt_reg,    gnt_next;
    logic [1:0]    y_reg,      y_next;
    logic          valid_reg,  valid_next;
    logic          expire_reg, expire_next;

    logic [3:0] owner_oh;
    logic [3:0] others;
    logic       others_any;
    logic [2:0] pick_all;
    logic [2:0] pick_others;

    // First set bit of m, searching p, p+1, p+2, p+3 (mod 4).
    // Returns {found, index}; the 2-bit sum wraps naturally.
    function automatic logic [2:0] pick_fn(input logic [1:0] p, input logic [3:0] m);
        logic [2:0] r;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if (m[p + 2'(k)]) begin
                r = {1'b1, p + 2'(k)};
            end
        end
        return r;
    endfunction

    // One-hot decode of the current owner, one bit per requester.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_owner_oh
            assign owner_oh[gi] = (owner_reg == 2'(gi));
        end
    endgenerate

    // Requests other than the current owner; these are what the hold limit protects.
    assign others      = req & ~owner_oh;
    assign others_any  = |others;
    assign pick_all    = pick_fn(ptr_reg, req);
    assign pick_others = pick_fn(ptr_reg, others);

    // Next-state decision: new grant, release to idle, expiry, or keep.
    always_comb begin
        logic       do_grant;
        logic [1:0] grant_idx;

        state_next  = state_reg;
        ptr_next    = ptr_reg;
        owner_next  = owner_reg;
        cnt_next    = cnt_reg;
        gnt_next    = gnt_reg;
        y_next      = y_reg;
        valid_next  = valid_reg;
        expire_next = 1'b0;
        do_grant    = 1'b0;
        grant_idx   = 2'd0;

        case (state_reg)
            ST_IDLE: begin
                if (pick_all[2]) begin
                    do_grant  = 1'b1;
                    grant_idx = pick_all[1:0];
                end
            end
            default: begin
                if (!req[owner_reg]) begin
                    // Owner released: hand off on the same edge if anyone else waits.
                    if (pick_all[2]) begin
                        do_grant  = 1'b1;
                        grant_idx = pick_all[1:0];
                    end else begin
                        state_next = ST_IDLE;
                        gnt_next   = 4'b0000;
                        valid_next = 1'b0;
                        cnt_next   = '0;
                    end
                end else if (HOLD_EN && (cnt_reg == HOLD_LAST)) begin
                    // Hold budget used up: revoke only if someone else is waiting.
                    if (others_any) begin
                        do_grant    = 1'b1;
                        grant_idx   = pick_others[1:0];
                        expire_next = 1'b1;
                    end else begin
                        cnt_next = '0;
                    end
                end else if (HOLD_EN && others_any) begin
                    // Contended hold: count up, saturating at the last allowed cycle.
                    if (cnt_reg != HOLD_LAST) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    // Lone owner (or no limit): never accumulates hold time.
                    cnt_next = '0;
                end
            end
        endcase

        if (do_grant) begin
            state_next = ST_GRANT;
            owner_next = grant_idx;
            ptr_next   = grant_idx + 2'd1;
            cnt_next   = '0;
            gnt_next   = 4'b0001 << grant_idx;
            y_next     = grant_idx;
            valid_next = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= 2'd0;
            owner_reg  <= 2'd0;
            cnt_reg    <= '0;
            gnt_reg    <= 4'b0000;
            y_reg      <= 2'd0;
            valid_reg  <= 1'b0;
            expire_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            owner_reg  <= owner_next;
            cnt_reg    <= cnt_next;
            gnt_reg    <= gnt_next;
            y_reg      <= y_next;
            valid_reg  <= valid_next;
            expire_reg <= expire_next;
        end
    end

    assign gnt    = gnt_reg;
    assign y      = y_reg;
    assign valid  = valid_reg;
    assign expire = expire_reg;

endmodule

// File: tb/tb_rr_arb4x2.sv
// Bench for rr_arb4x2 with MAX_HOLD=4: directed request vectors, a
// cycle-level behavioural model checked on every edge, and hand-computed
// literal expectations at the key points of each scenario.
module tb_rr_arb4x2;

    localparam int MAX_HOLD = 4;
    localparam int CW       = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] y;
    logic       valid;
    logic       expire;

    int checks = 0;
    int errors = 0;

    rr_arb4x2 #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .y     (y),
        .valid (valid),
        .expire(expire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_owner;   // -1 when nobody holds the resource
    int         m_ptr;
    int         m_held;    // contended cycles the owner has already held
    logic [3:0] m_gnt;
    logic [1:0] m_y;
    logic       m_valid;
    logic       m_expire;

    function automatic int pick(input int p, input logic [3:0] m);
        for (int k = 0; k < 4; k++) begin
            if (m[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic m_give(input int i);
        m_owner = i;
        m_ptr   = (i + 1) % 4;
        m_held  = 0;
        m_gnt   = 4'(1 << i);
        m_y     = 2'(i);
        m_valid = 1'b1;
    endtask

    task automatic model_step(input logic rn, input logic [3:0] r);
        logic [3:0] rest;
        if (!rn) begin
            m_owner = -1; m_ptr = 0; m_held = 0;
            m_gnt = 4'b0; m_y = 2'b0; m_valid = 1'b0; m_expire = 1'b0;
            return;
        end
        m_expire = 1'b0;
        if (m_owner < 0) begin
            if (r != 4'b0) m_give(pick(m_ptr, r));
            return;
        end
        rest = r;
        rest[m_owner] = 1'b0;
        if (!r[m_owner]) begin
            if (r != 4'b0) m_give(pick(m_ptr, r));
            else begin
                m_owner = -1; m_held = 0; m_gnt = 4'b0; m_valid = 1'b0;
            end
        end else if (rest != 4'b0) begin
            // Owner has now been granted m_held+1 contended cycles.
            if (m_held + 1 >= MAX_HOLD) begin
                m_give(pick(m_ptr, rest));
                m_expire = 1'b1;
            end else begin
                m_held = m_held + 1;
            end
        end else begin
            m_held = 0;
        end
    endtask

    // Per-edge compare: advance the model with the sampled inputs, then check.
    always @(posedge clk) begin
        logic       rn_s;
        logic [3:0] req_s;
        rn_s  = rst_n;
        req_s = req;
        model_step(rn_s, req_s);
        #1;
        check("gnt", gnt, m_gnt);
        check("y", {2'b00, y}, {2'b00, m_y});
        check("valid", {3'b000, valid}, {3'b000, m_valid});
        check("expire", {3'b000, expire}, {3'b000, m_expire});
        check("onehot", {3'b000, $onehot0(gnt)}, 4'b0001);
        check("valid_or", {3'b000, valid ^ (|gnt)}, 4'b0000);
    end

    // Apply inputs at a falling edge and wait one full cycle.
    task automatic drive(input logic rn, input logic [3:0] r);
        rst_n = rn;
        req   = r;
        @(negedge clk);
    endtask

    logic [3:0] mix_tab [0:11];

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        mix_tab = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0110,
                    4'b1001, 4'b1001, 4'b0000, 4'b0101, 4'b1010, 4'b0000};
        @(negedge clk);

        // Reset held with all requests up.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b1111);
            check("rst_gnt", gnt, 4'b0000);
            check("rst_y", {2'b00, y}, 4'b0000);
            check("rst_valid", {3'b000, valid}, 4'b0000);
            check("rst_expire", {3'b000, expire}, 4'b0000);
        end
        drive(1'b1, 4'b1111);
        check("first_gnt", gnt, 4'b0001);
        check("first_y", {2'b00, y}, 4'b0000);

        // Round-robin: each owner drops its bit after two grant cycles.
        drive(1'b1, 4'b1111);
        drive(1'b1, 4'b1110);
        check("rr_gnt1", gnt, 4'b0010);
        check("rr_y1", {2'b00, y}, 4'b0001);
        drive(1'b1, 4'b1111);
        drive(1'b1, 4'b1101);
        check("rr_gnt2", gnt, 4'b0100);
        check("rr_y2", {2'b00, y}, 4'b0010);
        drive(1'b1, 4'b1111);
        drive(1'b1, 4'b1011);
        check("rr_gnt3", gnt, 4'b1000);
        check("rr_y3", {2'b00, y}, 4'b0011);
        drive(1'b1, 4'b1111);
        drive(1'b1, 4'b0111);
        check("rr_gnt0", gnt, 4'b0001);
        check("rr_y0", {2'b00, y}, 4'b0000);
        drive(1'b1, 4'b0000);
        check("rr_idle", gnt, 4'b0000);

        // Single requester x3: granted, never expires, y holds after drop.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b0100);
            check("single_gnt", gnt, 4'b0100);
            check("single_exp", {3'b000, expire}, 4'b0000);
        end
        drive(1'b1, 4'b0000);
        check("single_drop", gnt, 4'b0000);
        check("single_valid", {3'b000, valid}, 4'b0000);
        check("single_yhold", {2'b00, y}, 4'b0010);

        // Pointer wrap: x4 releases with x1/x2 waiting -> x1 wins.
        drive(1'b1, 4'b1000);
        check("wrap_own", gnt, 4'b1000);
        drive(1'b1, 4'b1011);
        check("wrap_hold", gnt, 4'b1000);
        drive(1'b1, 4'b0011);
        check("wrap_gnt", gnt, 4'b0001);
        check("wrap_y", {2'b00, y}, 4'b0000);
        drive(1'b1, 4'b0000);

        // Hold limit: x1 held, x3 waits; four contended cycles then expiry.
        drive(1'b1, 4'b0001);
        check("hold_start", gnt, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b0101);
            check("hold_keep", gnt, 4'b0001);
            check("hold_noexp", {3'b000, expire}, 4'b0000);
        end
        drive(1'b1, 4'b0101);
        check("hold_handoff", gnt, 4'b0100);
        check("hold_y", {2'b00, y}, 4'b0010);
        check("hold_expire", {3'b000, expire}, 4'b0001);
        drive(1'b1, 4'b0101);
        check("hold_pulse1", {3'b000, expire}, 4'b0000);
        for (int i = 0; i < 4; i++) drive(1'b1, 4'b0101);
        check("hold_back", gnt, 4'b0001);
        drive(1'b1, 4'b0000);

        // Reset mid-grant drops the grant without an expire pulse.
        drive(1'b1, 4'b0010);
        check("mid_gnt", gnt, 4'b0010);
        drive(1'b1, 4'b0010);
        drive(1'b0, 4'b0010);
        check("mid_rst_gnt", gnt, 4'b0000);
        check("mid_rst_exp", {3'b000, expire}, 4'b0000);
        drive(1'b1, 4'b0010);
        check("mid_regnt", gnt, 4'b0010);
        check("mid_y", {2'b00, y}, 4'b0001);
        drive(1'b1, 4'b0000);

        // Mixed contention, checked by the per-edge model only.
        for (int i = 0; i < 12; i++) drive(1'b1, mix_tab[i]);
        drive(1'b1, 4'b0000);
        drive(1'b1, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
